ca3_theta_scheduler: RTL and testbench
======================================

Name: ca3_theta_scheduler

Overview:
Theta-phase sequencer for the CA3 phase memory. It arbitrates encode and recall requests from two requesters and waits for the correct theta phase: encode opens at the theta peak, recall at the theta trough. It then drives the memory's learn/recall strobes and pattern bus for fixed windows, counted in 4 kHz update ticks. It sits between thalamic theta (thalamic_theta_x) and ca3_mem inside phi_n_neural_processor.

Parameters:
WIDTH, 18, theta sample width (signed, Q4.14)
PEAK_THRESH, 12288, theta level that opens an encode window
TROUGH_THRESH, -12288, theta level that opens a recall window
HYST, 2000, theta must fall below PEAK_THRESH-HYST before an encode completes
ENC_UPDATES, 30, encode window length in ticks
REC_UPDATES, 50, recall window length in ticks
REFRACT_UPDATES, 20, post-window dead time in ticks
TIMEOUT_UPDATES, 4000, maximum ticks spent waiting for a phase

Ports:
clk  in  1  system clock (125 MHz)
rst  in  1  asynchronous, active-low reset
clk_en  in  1  4 kHz update tick, one clk wide
enable  in  1  scheduler enable; low aborts any operation
theta_x  in  WIDTH  signed theta oscillator output
enc_req  in  1  encode request (level)
enc_pattern  in  6  pattern to store
enc_ack  out  1  one-cycle grant pulse
rec_req  in  1  recall request (level)
rec_cue  in  6  recall cue
rec_ack  out  1  one-cycle grant pulse
mem_learn  out  1  CA3 learning strobe
mem_recall  out  1  CA3 recall strobe
mem_pattern_in  out  6  pattern/cue bus to CA3
mem_pattern_out  in  6  CA3 recalled pattern
enc_done  out  1  one-cycle completion pulse
rec_done  out  1  one-cycle completion pulse
rec_result  out  6  pattern captured at the end of recall
timeout  out  1  one-cycle pulse sent with done when a phase wait expired
busy  out  1  high whenever the state is not IDLE
learn_count  out  16  completed encodes, saturating at 0xFFFF

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Counters 0. last_grant=REC, so the first tie goes to encode.
- States: IDLE, WAIT_PEAK, ENCODE, WAIT_FALL, WAIT_TROUGH, RECALL, REFRACT.
- Grants are evaluated every clk, not gated by clk_en.
  - IDLE with enable=1: if exactly one request is high, grant it.
  - If both are high, grant the opposite of last_grant (round-robin).
  - Grant actions: latch the pattern/cue, pulse the ack in the same cycle, update last_grant, clear the wait counter.
  - Next state: WAIT_PEAK (encode) or WAIT_TROUGH (recall).
- All later transitions and counter decrements happen only on cycles with clk_en=1.
- WAIT_PEAK:
  - theta_x >= PEAK_THRESH -> ENCODE, load window counter = ENC_UPDATES.
  - Otherwise increment the wait counter. On reaching TIMEOUT_UPDATES -> REFRACT, pulse enc_done and timeout together.
- ENCODE:
  - mem_learn=1 and mem_pattern_in=latched pattern, registered, asserted from the first cycle of the state.
  - Decrement on each tick. When the counter reaches 0 -> WAIT_FALL with mem_learn=0.
  - Exactly ENC_UPDATES ticks have mem_learn high.
- WAIT_FALL: theta_x < PEAK_THRESH-HYST -> REFRACT. Pulse enc_done and increment learn_count (saturating).
- WAIT_TROUGH: theta_x <= TROUGH_THRESH -> RECALL, counter = REC_UPDATES. Timeout handling is identical to WAIT_PEAK but pulses rec_done.
- RECALL:
  - mem_recall=1 and mem_pattern_in=cue.
  - On the final tick (counter 1 -> 0): capture mem_pattern_out into rec_result, pulse rec_done, go to REFRACT.
  - rec_result holds its value until the next recall completes.
- REFRACT:
  - mem_pattern_in=0 and both strobes low.
  - Stay REFRACT_UPDATES ticks, then IDLE.
  - Requests are ignored while in REFRACT.
- mem_learn and mem_recall are never high simultaneously. mem_pattern_in=0 outside ENCODE/RECALL.
- A request dropped after its ack has no effect: the operation completes.
- enable=0 in any state: next clk go to IDLE and deassert strobes. No done pulse and no learn_count change. rec_result is retained.
- clk_en coinciding with a grant cycle: the grant still happens, and the phase check starts on the next tick.
- Theta comparisons are signed, full WIDTH.
- All outputs are registered.

Test Plan:
- Reset mid-ENCODE (rst low for 3 clk) -> mem_learn=0 immediately (async), busy=0, learn_count=0, and the next grant goes to encode when both requests are high.
- enc_req with pattern 101010, theta sweeping through 12288 -> enc_ack one clk; mem_learn high for exactly 30 ticks starting at the first tick with theta>=12288; mem_pattern_in=101010; enc_done after theta<10288; learn_count=1.
- rec_req with cue 100000 and a CA3 model returning 101010 -> mem_recall for 50 ticks starting at theta<=-12288; rec_result=101010; rec_done one clk; mem_learn never high.
- enc_req and rec_req held together for 4 operations -> grant order enc, rec, enc, rec; 20 dead ticks after each done before the next ack.
- theta held at 0 with an encode pending -> after 4000 ticks enc_done and timeout pulse in the same cycle; learn_count unchanged; return to IDLE after 20 ticks.
- enable dropped at tick 10 of RECALL -> strobe low the next clk, no rec_done, rec_result unchanged; a new request is accepted once enable=1.

Source files
------------

// File: rtl/ca3_theta_scheduler.sv
`timescale 1ns/1ps
// Theta-phase sequencer for CA3: arbitrates encode/recall requests, waits for the
// theta peak (encode) or trough (recall), then drives learn/recall windows.
module ca3_theta_scheduler #(
  parameter int WIDTH           = 18,
  parameter int PEAK_THRESH     = 12288,
  parameter int TROUGH_THRESH   = -12288,
  parameter int HYST            = 2000,
  parameter int ENC_UPDATES     = 30,
  parameter int REC_UPDATES     = 50,
  parameter int REFRACT_UPDATES = 20,
  parameter int TIMEOUT_UPDATES = 4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             enable,
  input  logic [WIDTH-1:0] theta_x,
  input  logic             enc_req,
  input  logic [5:0]       enc_pattern,
  output logic             enc_ack,
  input  logic             rec_req,
  input  logic [5:0]       rec_cue,
  output logic             rec_ack,
  output logic             mem_learn,
  output logic             mem_recall,
  output logic [5:0]       mem_pattern_in,
  input  logic [5:0]       mem_pattern_out,
  output logic             enc_done,
  output logic             rec_done,
  output logic [5:0]       rec_result,
  output logic             timeout,
  output logic             busy,
  output logic [15:0]      learn_count
);

  localparam int WIN_MAX = (ENC_UPDATES > REC_UPDATES)
                         ? ((ENC_UPDATES > REFRACT_UPDATES) ? ENC_UPDATES : REFRACT_UPDATES)
                         : ((REC_UPDATES > REFRACT_UPDATES) ? REC_UPDATES : REFRACT_UPDATES);
  localparam int WIN_W  = $clog2(WIN_MAX + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_UPDATES + 1);

  localparam logic [WIN_W-1:0]  ENC_LEN  = WIN_W'(ENC_UPDATES);
  localparam logic [WIN_W-1:0]  REC_LEN  = WIN_W'(REC_UPDATES);
  localparam logic [WIN_W-1:0]  REF_LEN  = WIN_W'(REFRACT_UPDATES);
  localparam logic [WIN_W-1:0]  WIN_ONE  = WIN_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_UPDATES);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  localparam logic signed [WIDTH-1:0] PEAK_S   = WIDTH'(PEAK_THRESH);
  localparam logic signed [WIDTH-1:0] FALL_S   = WIDTH'(PEAK_THRESH - HYST);
  localparam logic signed [WIDTH-1:0] TROUGH_S = WIDTH'(TROUGH_THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PEAK,
    S_ENCODE,
    S_WAIT_FALL,
    S_WAIT_TROUGH,
    S_RECALL,
    S_REFRACT
  } state_t;

  typedef enum logic {GRANT_ENC, GRANT_REC} grant_t;

  state_t              state_q, state_d;
  grant_t              last_grant_q, last_grant_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [5:0]          pat_q, pat_d;
  logic                enc_ack_q, enc_ack_d;
  logic                rec_ack_q, rec_ack_d;
  logic                mem_learn_q, mem_learn_d;
  logic                mem_recall_q, mem_recall_d;
  logic [5:0]          mem_pat_q, mem_pat_d;
  logic                enc_done_q, enc_done_d;
  logic                rec_done_q, rec_done_d;
  logic [5:0]          rec_result_q, rec_result_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;
  logic [15:0]         learn_cnt_q, learn_cnt_d;
  logic                grant_enc;
  logic signed [WIDTH-1:0] theta_s;

  assign theta_s = $signed(theta_x);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    win_cnt_d    = win_cnt_q;
    pat_d        = pat_q;
    enc_ack_d    = 1'b0;
    rec_ack_d    = 1'b0;
    enc_done_d   = 1'b0;
    rec_done_d   = 1'b0;
    timeout_d    = 1'b0;
    mem_learn_d  = mem_learn_q;
    mem_recall_d = mem_recall_q;
    mem_pat_d    = mem_pat_q;
    rec_result_d = rec_result_q;
    learn_cnt_d  = learn_cnt_q;
    wait_inc     = wait_cnt_q + WAIT_ONE;
    // A lone request wins outright; on a tie the side not granted last time wins.
    grant_enc    = enc_req && (!rec_req || (last_grant_q == GRANT_REC));

    if (!enable) begin
      state_d      = S_IDLE;
      mem_learn_d  = 1'b0;
      mem_recall_d = 1'b0;
      mem_pat_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enc_req || rec_req) begin
            wait_cnt_d = '0;
            if (grant_enc) begin
              pat_d        = enc_pattern;
              enc_ack_d    = 1'b1;
              last_grant_d = GRANT_ENC;
              state_d      = S_WAIT_PEAK;
            end else begin
              pat_d        = rec_cue;
              rec_ack_d    = 1'b1;
              last_grant_d = GRANT_REC;
              state_d      = S_WAIT_TROUGH;
            end
          end
        end
        S_WAIT_PEAK: begin
          if (clk_en) begin
            if (theta_s >= PEAK_S) begin
              state_d     = S_ENCODE;
              win_cnt_d   = ENC_LEN;
              mem_learn_d = 1'b1;
              mem_pat_d   = pat_q;
            end else if (wait_inc == WAIT_MAX) begin
              state_d    = S_REFRACT;
              win_cnt_d  = REF_LEN;
              enc_done_d = 1'b1;
              timeout_d  = 1'b1;
            end else begin
              wait_cnt_d = wait_inc;
            end
          end
        end
        S_ENCODE: begin
          if (clk_en) begin
            win_cnt_d = win_cnt_q - WIN_ONE;
            if (win_cnt_q == WIN_ONE) begin
              state_d     = S_WAIT_FALL;
              mem_learn_d = 1'b0;
              mem_pat_d   = '0;
            end
          end
        end
        S_WAIT_FALL: begin
          if (clk_en && (theta_s < FALL_S)) begin
            state_d    = S_REFRACT;
            win_cnt_d  = REF_LEN;
            enc_done_d = 1'b1;
            if (learn_cnt_q != 16'hFFFF) learn_cnt_d = learn_cnt_q + 16'd1;
          end
        end
        S_WAIT_TROUGH: begin
          if (clk_en) begin
            if (theta_s <= TROUGH_S) begin
              state_d      = S_RECALL;
              win_cnt_d    = REC_LEN;
              mem_recall_d = 1'b1;
              mem_pat_d    = pat_q;
            end else if (wait_inc == WAIT_MAX) begin
              state_d    = S_REFRACT;
              win_cnt_d  = REF_LEN;
              rec_done_d = 1'b1;
              timeout_d  = 1'b1;
            end else begin
              wait_cnt_d = wait_inc;
            end
          end
        end
        S_RECALL: begin
          if (clk_en) begin
            win_cnt_d = win_cnt_q - WIN_ONE;
            if (win_cnt_q == WIN_ONE) begin
              state_d      = S_REFRACT;
              win_cnt_d    = REF_LEN;
              rec_result_d = mem_pattern_out;
              rec_done_d   = 1'b1;
              mem_recall_d = 1'b0;
              mem_pat_d    = '0;
            end
          end
        end
        S_REFRACT: begin
          if (clk_en) begin
            win_cnt_d = win_cnt_q - WIN_ONE;
            if (win_cnt_q == WIN_ONE) state_d = S_IDLE;
          end
        end
        default: begin
          state_d      = S_IDLE;
          mem_learn_d  = 1'b0;
          mem_recall_d = 1'b0;
          mem_pat_d    = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_REC;
      wait_cnt_q   <= '0;
      win_cnt_q    <= '0;
      pat_q        <= '0;
      enc_ack_q    <= 1'b0;
      rec_ack_q    <= 1'b0;
      mem_learn_q  <= 1'b0;
      mem_recall_q <= 1'b0;
      mem_pat_q    <= '0;
      enc_done_q   <= 1'b0;
      rec_done_q   <= 1'b0;
      rec_result_q <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      learn_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      win_cnt_q    <= win_cnt_d;
      pat_q        <= pat_d;
      enc_ack_q    <= enc_ack_d;
      rec_ack_q    <= rec_ack_d;
      mem_learn_q  <= mem_learn_d;
      mem_recall_q <= mem_recall_d;
      mem_pat_q    <= mem_pat_d;
      enc_done_q   <= enc_done_d;
      rec_done_q   <= rec_done_d;
      rec_result_q <= rec_result_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
      learn_cnt_q  <= learn_cnt_d;
    end
  end

  assign enc_ack        = enc_ack_q;
  assign rec_ack        = rec_ack_q;
  assign mem_learn      = mem_learn_q;
  assign mem_recall     = mem_recall_q;
  assign mem_pattern_in = mem_pat_q;
  assign enc_done       = enc_done_q;
  assign rec_done       = rec_done_q;
  assign rec_result     = rec_result_q;
  assign timeout        = timeout_q;
  assign busy           = busy_q;
  assign learn_count    = learn_cnt_q;

endmodule

// File: tb/tb_ca3_theta_scheduler.sv
`timescale 1ns/1ps
// Bench for ca3_theta_scheduler: grant/threshold vector table plus directed
// encode, recall, round-robin, timeout, reset and abort sequences.
module tb_ca3_theta_scheduler;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clk_en = 1'b0;
  logic               enable = 1'b1;
  logic signed [17:0] theta_x = '0;
  logic               enc_req = 1'b0;
  logic [5:0]         enc_pattern = '0;
  logic               enc_ack;
  logic               rec_req = 1'b0;
  logic [5:0]         rec_cue = '0;
  logic               rec_ack;
  logic               mem_learn;
  logic               mem_recall;
  logic [5:0]         mem_pattern_in;
  logic [5:0]         mem_pattern_out;
  logic               enc_done;
  logic               rec_done;
  logic [5:0]         rec_result;
  logic               timeout;
  logic               busy;
  logic [15:0]        learn_count;

  ca3_theta_scheduler dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .enable(enable), .theta_x(theta_x),
    .enc_req(enc_req), .enc_pattern(enc_pattern), .enc_ack(enc_ack),
    .rec_req(rec_req), .rec_cue(rec_cue), .rec_ack(rec_ack),
    .mem_learn(mem_learn), .mem_recall(mem_recall),
    .mem_pattern_in(mem_pattern_in), .mem_pattern_out(mem_pattern_out),
    .enc_done(enc_done), .rec_done(rec_done), .rec_result(rec_result),
    .timeout(timeout), .busy(busy), .learn_count(learn_count)
  );

  // CA3 stand-in: recalled pattern is the cue with bits 3 and 1 flipped.
  assign mem_pattern_out = mem_recall ? (mem_pattern_in ^ 6'b001010) : 6'b000000;

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event monitor, sampled on the falling edge.
  int learn_ticks = 0, recall_ticks = 0, learn_hi = 0, ack_cnt = 0;
  int enc_done_cnt = 0, rec_done_cnt = 0;
  int pulse_err = 0, overlap_err = 0, pat_err = 0, to_err = 0;
  logic learn_prev = 1'b0, recall_prev = 1'b0;
  logic eack_p = 1'b0, rack_p = 1'b0, edone_p = 1'b0, rdone_p = 1'b0, to_p = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      learn_prev = 1'b0; recall_prev = 1'b0;
      eack_p = 1'b0; rack_p = 1'b0; edone_p = 1'b0; rdone_p = 1'b0; to_p = 1'b0;
    end else begin
      if (clk_en && learn_prev)  learn_ticks++;
      if (clk_en && recall_prev) recall_ticks++;
      learn_prev  = mem_learn;
      recall_prev = mem_recall;
      if (mem_learn) learn_hi++;
      if (enc_ack || rec_ack) ack_cnt++;
      if (enc_done) enc_done_cnt++;
      if (rec_done) rec_done_cnt++;
      if ((enc_ack && eack_p) || (rec_ack && rack_p) || (enc_done && edone_p) ||
          (rec_done && rdone_p) || (timeout && to_p)) pulse_err++;
      if (mem_learn && mem_recall) overlap_err++;
      if (!mem_learn && !mem_recall && (mem_pattern_in != 6'd0)) pat_err++;
      if (timeout && !(enc_done || rec_done)) to_err++;
      eack_p = enc_ack; rack_p = rec_ack; edone_p = enc_done; rdone_p = rec_done; to_p = timeout;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    cyc();
    clk_en = 1'b1;
    cyc();
    clk_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Runs one granted operation from its phase wait to the done pulse.
  task automatic run_op(input bit is_enc);
    theta_x = is_enc ? 18'sd13000 : -18'sd13000;
    tick();
    check(is_enc ? "op_learn_on" : "op_recall_on", 32'(is_enc ? mem_learn : mem_recall), 32'd1);
    ticks(is_enc ? 30 : 50);
    if (is_enc) begin
      theta_x = 18'sd0;
      tick();
    end
  endtask

  typedef struct {
    logic               enc;
    logic               rec;
    logic [5:0]         pat;
    logic signed [17:0] theta;
    logic               tick_g;
    logic               exp_eack;
    logic               exp_rack;
    logic               exp_learn;
    logic               exp_recall;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #400us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lt0, rt0, lh0, ac0, ed0, rd0;
    logic exp_enc;

    vecs[0] = '{1'b1, 1'b0, 6'b000001,  18'sd12287,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 6'b000010,  18'sd12288,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 6'b000011, -18'sd12287,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 6'b000100,  18'h20000,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 6'b000101, -18'sd12288,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 6'b000110,  18'h1FFFF,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 6'b000111,  18'h1FFFF,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 6'b001000,  18'h20000,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_learn", 32'(mem_learn), 32'd0);
    check("rst_recall", 32'(mem_recall), 32'd0);
    check("rst_pattern", 32'(mem_pattern_in), 32'd0);
    check("rst_learn_count", 32'(learn_count), 32'd0);
    check("rst_rec_result", 32'(rec_result), 32'd0);
    rst = 1'b1;
    cyc();

    // Grant arbitration and signed threshold vectors; each op is aborted via enable.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = vecs[i];
      enc_req = v.enc; rec_req = v.rec;
      enc_pattern = v.pat; rec_cue = v.pat;
      theta_x = v.theta;
      clk_en = v.tick_g;
      cyc();
      clk_en = 1'b0;
      check("tbl_enc_ack", 32'(enc_ack), 32'(v.exp_eack));
      check("tbl_rec_ack", 32'(rec_ack), 32'(v.exp_rack));
      check("tbl_grant_strobes", 32'({mem_learn, mem_recall}), 32'd0);
      enc_req = 1'b0; rec_req = 1'b0;
      tick();
      check("tbl_learn", 32'(mem_learn), 32'(v.exp_learn));
      check("tbl_recall", 32'(mem_recall), 32'(v.exp_recall));
      check("tbl_pattern", 32'(mem_pattern_in), (v.exp_learn || v.exp_recall) ? 32'(v.pat) : 32'd0);
      enable = 1'b0;
      cyc();
      check("tbl_abort_busy", 32'(busy), 32'd0);
      enable = 1'b1;
    end

    // Encode with theta sweeping through the peak threshold.
    theta_x = 18'sd0;
    enc_pattern = 6'b101010; enc_req = 1'b1;
    cyc();
    check("enc_ack", 32'(enc_ack), 32'd1);
    check("enc_busy", 32'(busy), 32'd1);
    enc_req = 1'b0; enc_pattern = 6'b000000;
    lh0 = learn_hi; ed0 = enc_done_cnt;
    theta_x = 18'sd0;     tick();
    theta_x = 18'sd6000;  tick();
    theta_x = 18'sd12000; tick();
    theta_x = 18'sd12287; tick();
    check("enc_no_early_learn", 32'(learn_hi - lh0), 32'd0);
    lt0 = learn_ticks;
    theta_x = 18'sd12288; tick();
    check("enc_learn_start", 32'(mem_learn), 32'd1);
    check("enc_pattern_bus", 32'(mem_pattern_in), 32'h2A);
    theta_x = 18'sd14000;
    ticks(29);
    check("enc_learn_29", 32'(mem_learn), 32'd1);
    tick();
    check("enc_learn_end", 32'(mem_learn), 32'd0);
    check("enc_pattern_clear", 32'(mem_pattern_in), 32'd0);
    theta_x = 18'sd11000; tick();
    theta_x = 18'sd10288; tick();
    check("enc_hyst_hold", 32'(enc_done_cnt - ed0), 32'd0);
    theta_x = 18'sd10000; tick();
    check("enc_done", 32'(enc_done), 32'd1);
    check("enc_timeout", 32'(timeout), 32'd0);
    check("enc_learn_count", 32'(learn_count), 32'd1);
    check("enc_learn_ticks", 32'(learn_ticks - lt0), 32'd30);
    ac0 = ack_cnt;
    enc_req = 1'b1;
    ticks(19);
    check("enc_refract_busy", 32'(busy), 32'd1);
    tick();
    check("enc_refract_idle", 32'(busy), 32'd0);
    check("enc_refract_no_ack", 32'(ack_cnt - ac0), 32'd0);
    cyc();
    check("enc_post_refract_ack", 32'(enc_ack), 32'd1);
    enc_req = 1'b0; enable = 1'b0;
    cyc();
    enable = 1'b1;

    // Recall with cue 100000; the memory model returns 101010.
    rec_cue = 6'b100000; rec_req = 1'b1;
    cyc();
    check("rec_ack", 32'(rec_ack), 32'd1);
    rec_req = 1'b0; rec_cue = 6'b000000;
    lh0 = learn_hi; rd0 = rec_done_cnt;
    theta_x = -18'sd12000; tick();
    theta_x = -18'sd12287; tick();
    check("rec_no_early_recall", 32'(mem_recall), 32'd0);
    rt0 = recall_ticks;
    theta_x = -18'sd12288; tick();
    check("rec_recall_start", 32'(mem_recall), 32'd1);
    check("rec_cue_bus", 32'(mem_pattern_in), 32'h20);
    ticks(49);
    check("rec_recall_49", 32'(mem_recall), 32'd1);
    check("rec_no_early_done", 32'(rec_done_cnt - rd0), 32'd0);
    tick();
    check("rec_done", 32'(rec_done), 32'd1);
    check("rec_result", 32'(rec_result), 32'h2A);
    check("rec_recall_end", 32'(mem_recall), 32'd0);
    check("rec_recall_ticks", 32'(recall_ticks - rt0), 32'd50);
    check("rec_no_learn", 32'(learn_hi - lh0), 32'd0);
    ticks(20);
    check("rec_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of an encode window.
    enc_pattern = 6'b110011; enc_req = 1'b1;
    cyc();
    enc_req = 1'b0;
    theta_x = 18'sd13000; tick();
    ticks(3);
    check("rstm_learn_before", 32'(mem_learn), 32'd1);
    rst = 1'b0;
    #1;
    check("rstm_learn", 32'(mem_learn), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_learn_count", 32'(learn_count), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;

    // Both requests held: enc, rec, enc, rec with 20 dead ticks between.
    enc_pattern = 6'b000111; rec_cue = 6'b100000;
    enc_req = 1'b1; rec_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_enc = (i % 2 == 0);
      cyc();
      check("rr_enc_ack", 32'(enc_ack), 32'(exp_enc));
      check("rr_rec_ack", 32'(rec_ack), 32'(!exp_enc));
      run_op(exp_enc);
      check("rr_done", 32'(exp_enc ? enc_done : rec_done), 32'd1);
      ac0 = ack_cnt;
      ticks(19);
      check("rr_dead_busy", 32'(busy), 32'd1);
      tick();
      check("rr_dead_idle", 32'(busy), 32'd0);
      check("rr_dead_no_ack", 32'(ack_cnt - ac0), 32'd0);
      if (i == 3) begin
        enc_req = 1'b0; rec_req = 1'b0;
      end
    end
    check("rr_learn_count", 32'(learn_count), 32'd2);

    // Theta parked at zero: the peak wait expires.
    theta_x = 18'sd0;
    enc_pattern = 6'b010101; enc_req = 1'b1;
    cyc();
    check("to_ack", 32'(enc_ack), 32'd1);
    enc_req = 1'b0;
    ed0 = enc_done_cnt;
    ticks(3999);
    check("to_not_yet", 32'(enc_done_cnt - ed0), 32'd0);
    check("to_busy_wait", 32'(busy), 32'd1);
    tick();
    check("to_done", 32'(enc_done), 32'd1);
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_learn_count", 32'(learn_count), 32'd2);
    ticks(19);
    check("to_refract_busy", 32'(busy), 32'd1);
    tick();
    check("to_idle", 32'(busy), 32'd0);

    // Enable dropped partway through a recall window.
    rec_cue = 6'b010101; rec_req = 1'b1;
    cyc();
    check("ab_ack", 32'(rec_ack), 32'd1);
    rec_req = 1'b0;
    theta_x = -18'sd13000; tick();
    ticks(10);
    check("ab_recall_before", 32'(mem_recall), 32'd1);
    rd0 = rec_done_cnt;
    enable = 1'b0;
    cyc();
    check("ab_recall_low", 32'(mem_recall), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_pattern", 32'(mem_pattern_in), 32'd0);
    ticks(3);
    check("ab_no_done", 32'(rec_done_cnt - rd0), 32'd0);
    check("ab_result_kept", 32'(rec_result), 32'h2A);
    enable = 1'b1;
    enc_pattern = 6'b111000; enc_req = 1'b1;
    cyc();
    check("ab_new_ack", 32'(enc_ack), 32'd1);
    enc_req = 1'b0; enable = 1'b0;
    cyc();
    enable = 1'b1;
    cyc();

    check("mon_pulse_width", 32'(pulse_err), 32'd0);
    check("mon_strobe_overlap", 32'(overlap_err), 32'd0);
    check("mon_pattern_idle", 32'(pat_err), 32'd0);
    check("mon_timeout_alone", 32'(to_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
